// File: rtl/tts_tx_encoder.sv
// TTS serial encoder for the AMC13 TTS line.
// Debounces the requested TTS code, waits a quiet period after reset,
// then streams back-to-back 12-bit frames: 1100, code, ~code (MSB first).
//
// state | meaning
// IDLE  | line held low while the post-reset quiet period counts down
// SEND  | continuous framing; a new frame loads whenever bit_cnt is 0
module tts_tx_encoder #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned IDLE_CYCLES   = 16
) (
  input  logic        clk_40,
  input  logic        rst_n,
  input  logic [3:0]  tts_state,
  output logic        tts_out,
  output logic        frame_start,
  output logic [3:0]  sent_state,
  output logic [15:0] frame_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [3:0] FILT_TC  = 4'(FILTER_CYCLES - 1);
  localparam logic [7:0] IDLE_TC  = 8'(IDLE_CYCLES - 1);
  localparam logic [3:0] CODE_OOS = 4'h2;

  state_t      state_q, state_d;
  logic [1:0]  rst_sync;
  logic        rst_ok;
  logic [3:0]  candidate;
  logic [3:0]  stable_cnt;
  logic [3:0]  adopted;
  logic        adopt_fire;
  logic [3:0]  adopt_next;
  logic [7:0]  idle_cnt;
  logic [3:0]  bit_cnt;
  logic [11:0] shreg;
  logic [15:0] frame_cnt;
  logic        load_frame;

  assign rst_ok      = rst_sync[1];
  assign tts_out     = shreg[11];
  assign frame_count = frame_cnt;

  // A code that has survived the filter on this edge is used by a frame loaded on the same edge.
  assign adopt_fire = (stable_cnt == FILT_TC) && (tts_state == candidate);
  assign adopt_next = adopt_fire ? candidate : adopted;

  // Two-flop release synchronizer: assertion is immediate, release is aligned to clk_40.
  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // Input filter: a code must be seen on consecutive edges before it is adopted.
  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) begin
      candidate  <= CODE_OOS;
      stable_cnt <= 4'd0;
      adopted    <= CODE_OOS;
    end else if (rst_ok) begin
      if (tts_state != candidate) begin
        candidate  <= tts_state;
        stable_cnt <= 4'd0;
      end else if (stable_cnt != FILT_TC) begin
        stable_cnt <= stable_cnt + 4'd1;
      end
      if (adopt_fire) adopted <= candidate;
    end
  end

  // State register.
  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and frame-load decision.
  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_ok && (idle_cnt == 8'd0)) begin
          state_d    = SEND;
          load_frame = 1'b1;
        end
      end
      SEND: begin
        if (bit_cnt == 4'd0) load_frame = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Quiet-period timer, bit counter, shift register and frame bookkeeping.
  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= IDLE_TC;
      bit_cnt     <= 4'd0;
      shreg       <= 12'd0;
      frame_start <= 1'b0;
      sent_state  <= CODE_OOS;
      frame_cnt   <= 16'd0;
    end else begin
      frame_start <= load_frame;
      if ((state_q == IDLE) && rst_ok && (idle_cnt != 8'd0)) begin
        idle_cnt <= idle_cnt - 8'd1;
      end
      if (load_frame) begin
        shreg      <= {4'b1100, adopt_next, ~adopt_next};
        sent_state <= adopt_next;
        frame_cnt  <= frame_cnt + 16'd1;
        bit_cnt    <= 4'd1;
      end else if (state_q == SEND) begin
        shreg   <= {shreg[10:0], 1'b0};
        bit_cnt <= (bit_cnt == 4'd11) ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_tts_tx_encoder.sv
// Directed bench for tts_tx_encoder: quiet period, framing, filter, mid-frame
// adoption, same-edge adoption, counter wrap and mid-frame reset.
`timescale 1ns/1ps
module tb_tts_tx_encoder;

  logic        clk_40;
  logic        rst_n;
  logic [3:0]  tts_state;
  logic        tts_out;
  logic        frame_start;
  logic [3:0]  sent_state;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [11:0] PAT_OOS   = 12'b110000101101;
  localparam logic [11:0] PAT_READY = 12'b110010000111;
  localparam logic [11:0] PAT_ERROR = 12'b110011000011;

  tts_tx_encoder #(.FILTER_CYCLES(4), .IDLE_CYCLES(16)) dut (
    .clk_40      (clk_40),
    .rst_n       (rst_n),
    .tts_state   (tts_state),
    .tts_out     (tts_out),
    .frame_start (frame_start),
    .sent_state  (sent_state),
    .frame_count (frame_count)
  );

  // 40 MHz clock.
  initial begin
    clk_40 = 1'b0;
    forever #12.5 clk_40 = ~clk_40;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_40);
      check({tag, "_line"}, 16'(tts_out), 16'd0);
      check({tag, "_fs"}, 16'(frame_start), 16'd0);
    end
  endtask

  // Checks nbits bits of a frame starting at bit 11; optionally changes
  // tts_state right after sampling bit chg_i and again after bit rev_i.
  task automatic expect_frame(input string tag, input logic [11:0] pat,
                              input logic [3:0] code, input logic [15:0] fc,
                              input int nbits, input int chg_i, input logic [3:0] chg_v,
                              input int rev_i, input logic [3:0] rev_v);
    for (int k = 0; k < nbits; k++) begin
      int i;
      logic [11:0] p;
      i = 11 - k;
      p = pat;
      @(negedge clk_40);
      check({tag, "_line"}, 16'(tts_out), 16'(p[i]));
      check({tag, "_fs"}, 16'(frame_start), (i == 11) ? 16'd1 : 16'd0);
      check({tag, "_sent"}, 16'(sent_state), 16'(code));
      check({tag, "_count"}, frame_count, fc);
      if (i == chg_i) tts_state = chg_v;
      if (i == rev_i) tts_state = rev_v;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tts_state = 4'h2;
    repeat (3) @(negedge clk_40);
    check("rst_line", 16'(tts_out), 16'd0);
    check("rst_fs", 16'(frame_start), 16'd0);
    check("rst_sent", 16'(sent_state), 16'h2);
    check("rst_count", frame_count, 16'd0);

    // Release: two sync edges plus 16 quiet cycles, then the first frame.
    rst_n = 1'b1;
    expect_idle("idle", 17);
    expect_frame("f1_oos", PAT_OOS, 4'h2, 16'd1, 12, -1, 4'h0, -1, 4'h0);
    expect_frame("f2_oos", PAT_OOS, 4'h2, 16'd2, 12, -1, 4'h0, -1, 4'h0);
    expect_frame("f3_oos", PAT_OOS, 4'h2, 16'd3, 12, -1, 4'h0, -1, 4'h0);

    // Three-cycle BUSY glitch must be filtered out.
    expect_frame("f4_glitch", PAT_OOS, 4'h2, 16'd4, 12, 8, 4'h4, 5, 4'h2);
    expect_frame("f5_glitch", PAT_OOS, 4'h2, 16'd5, 12, -1, 4'h0, -1, 4'h0);

    // READY adopted mid-frame: current frame stays OOS, next ones are READY.
    expect_frame("f6_pre_ready", PAT_OOS, 4'h2, 16'd6, 12, 11, 4'h8, -1, 4'h0);
    expect_frame("f7_ready", PAT_READY, 4'h8, 16'd7, 12, -1, 4'h0, -1, 4'h0);
    expect_frame("f8_ready", PAT_READY, 4'h8, 16'd8, 12, -1, 4'h0, -1, 4'h0);

    // ERROR adopted while bit 5 is on the line: frame completes as READY.
    expect_frame("f9_mid_adopt", PAT_READY, 4'h8, 16'd9, 12, 10, 4'hC, -1, 4'h0);
    // OOS adopted exactly on the load edge of the following frame: new value wins.
    expect_frame("f10_error", PAT_ERROR, 4'hC, 16'd10, 12, 4, 4'h2, -1, 4'h0);
    expect_frame("f11_same_edge", PAT_OOS, 4'h2, 16'd11, 12, -1, 4'h0, -1, 4'h0);

    // Counter wrap.
    dut.frame_cnt = 16'hFFFF;
    #1;
    check("wrap_preset", frame_count, 16'hFFFF);
    expect_frame("f12_wrap", PAT_OOS, 4'h2, 16'd0, 12, -1, 4'h0, -1, 4'h0);

    // Reset at frame bit 7: line drops at once, frame is abandoned.
    expect_frame("f13_partial", PAT_OOS, 4'h2, 16'd1, 5, -1, 4'h0, -1, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_line", 16'(tts_out), 16'd0);
    check("abort_fs", 16'(frame_start), 16'd0);
    check("abort_count", frame_count, 16'd0);
    check("abort_sent", 16'(sent_state), 16'h2);
    repeat (3) @(negedge clk_40);
    rst_n = 1'b1;
    expect_idle("idle2", 17);
    expect_frame("f14_resume", PAT_OOS, 4'h2, 16'd1, 12, -1, 4'h0, -1, 4'h0);
    expect_frame("f15_resume", PAT_OOS, 4'h2, 16'd2, 12, -1, 4'h0, -1, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
